// File: rtl/data_mem_pipe_if.sv
// Request/response bus of the data memory.
// The master (MEM stage) drives the request fields. The slave (data_mem_pipe)
// drives req_ready and the response fields.
//   req_valid / req_ready : request handshake, accepted when both are high
//   req_we                : 1 = write, 0 = read
//   req_be                : byte enables, MSB = lowest-address byte = data MSB
//   req_addr / req_wdata  : byte address and write data
//   rsp_valid             : one-cycle response strobe, strictly in order
//   rsp_rdata / rsp_err   : read data (0 for writes/errors), out-of-range flag
interface data_mem_pipe_if #(
  parameter int WORD_LEN = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [WORD_LEN/8-1:0] req_be;
  logic [WORD_LEN-1:0]   req_addr;
  logic [WORD_LEN-1:0]   req_wdata;
  logic                  rsp_valid;
  logic [WORD_LEN-1:0]   rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_pipe.sv
// Byte-addressable, word-wide data RAM with per-byte write enables, a
// valid/ready request port and an in-order, fixed-latency response stream.
// After reset (or a clr request) the whole array is swept to zero, one word
// per cycle, before requests are accepted.
// Ports:
//   clk         : clock, all state on the rising edge
//   rst         : asynchronous active-high reset
//   clr_i       : request to re-run the zero-fill sweep (honoured in RUN only)
//   init_busy_o : zero-fill sweep in progress
//   bus         : request/response bus (slave side)
module data_mem_pipe #(
  parameter int WORD_LEN     = 32,
  parameter int DEPTH_WORDS  = 256,
  parameter int BASE_ADDR    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  output logic           init_busy_o,
  data_mem_pipe_if.slave bus
);

  localparam int BYTES = WORD_LEN / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // One extra bit so the end-of-storage bound cannot wrap.
  localparam logic [WORD_LEN:0] BASE_EXT = (WORD_LEN + 1)'(BASE_ADDR);
  localparam logic [WORD_LEN:0] END_EXT  = (WORD_LEN + 1)'(BASE_ADDR + DEPTH_WORDS * BYTES);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;

  logic                init_active;
  logic                accept;
  logic                below_base;
  logic                above_end;
  logic                in_mem;
  logic [WORD_LEN-1:0] offset;
  logic [IDX_W-1:0]    idx;

  logic [BYTES-1:0]    lane_we;
  logic [IDX_W-1:0]    wr_idx;
  logic [WORD_LEN-1:0] wr_word;
  logic [WORD_LEN-1:0] rd_word;

  // First response stage: registered at the accept edge.
  logic v0_q, v0_d;
  logic err0_q, err0_d;
  logic use0_q, use0_d;
  logic [WORD_LEN-1:0] data0;

  // ---------------------------------------------------------------- control
  assign init_active   = (state_q == ST_INIT);
  assign init_busy_o   = init_active;
  assign bus.req_ready = (state_q == ST_RUN);
  assign accept        = bus.req_valid & bus.req_ready;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == IDX_W'(DEPTH_WORDS - 1)) begin
        state_d    = ST_RUN;
        init_ptr_d = '0;
      end
    end else if (clr_i) begin
      state_d    = ST_INIT;
      init_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // --------------------------------------------------------- address decode
  // BASE and END are word aligned, so comparing the raw byte address gives
  // the same region as comparing the aligned-down address.
  assign below_base = ({1'b0, bus.req_addr} < BASE_EXT);
  assign above_end  = ({1'b0, bus.req_addr} >= END_EXT);
  assign in_mem     = ~below_base & ~above_end;
  assign offset     = bus.req_addr - BASE_EXT[WORD_LEN-1:0];
  assign idx        = IDX_W'(offset >> LB);

  // ------------------------------------------------------------ write port
  // The sweep owns the write port during INIT; requests are never accepted
  // then because req_ready is low.
  always_comb begin
    lane_we = '0;
    wr_idx  = idx;
    wr_word = bus.req_wdata;
    if (init_active) begin
      lane_we = '1;
      wr_idx  = init_ptr_q;
      wr_word = '0;
    end else if (accept && bus.req_we && in_mem) begin
      lane_we = bus.req_be;
    end
  end

  // One byte-wide RAM per lane so each byte enable maps to its own write
  // strobe. The read is registered at the accept edge and returns the data
  // stored before that edge.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          mem[wr_idx] <= wr_word[gi*8 +: 8];
        end
        if (accept) begin
          rd_q <= mem[idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_q;
    end
  endgenerate

  // ------------------------------------------------------ response pipeline
  assign v0_d   = accept;
  assign err0_d = accept & above_end;
  assign use0_d = accept & ~bus.req_we & in_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q   <= 1'b0;
      err0_q <= 1'b0;
      use0_q <= 1'b0;
    end else begin
      v0_q   <= v0_d;
      err0_q <= err0_d;
      use0_q <= use0_d;
    end
  end

  // RAM output register is not reset; use0_q gates it so the response data
  // is zero in reset, for writes and for anything outside storage.
  assign data0 = use0_q ? rd_word : '0;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign bus.rsp_valid = v0_q;
      assign bus.rsp_err   = err0_q;
      assign bus.rsp_rdata = data0;
    end else begin : g_latn
      localparam int NS = READ_LATENCY - 1;
      logic                v_q    [NS];
      logic                err_q  [NS];
      logic [WORD_LEN-1:0] data_q [NS];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < NS; i++) begin
            v_q[i]    <= 1'b0;
            err_q[i]  <= 1'b0;
            data_q[i] <= '0;
          end
        end else begin
          v_q[0]    <= v0_q;
          err_q[0]  <= err0_q;
          data_q[0] <= data0;
          for (int i = 1; i < NS; i++) begin
            v_q[i]    <= v_q[i-1];
            err_q[i]  <= err_q[i-1];
            data_q[i] <= data_q[i-1];
          end
        end
      end

      assign bus.rsp_valid = v_q[NS-1];
      assign bus.rsp_err   = err_q[NS-1];
      assign bus.rsp_rdata = data_q[NS-1];
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench for data_mem_pipe (32-bit words, 256 words at 0x400,
// read latency 3). The issuing process computes each expected response from
// a word-array model and queues it; a monitor pops and compares whenever the
// DUT presents rsp_valid, including the response latency.
module tb_data_mem_pipe;
  localparam int LAT   = 3;
  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_i = 1'b0;
  logic init_busy_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int sweep_n;
  int rdy_bad;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];

  data_mem_pipe_if #(.WORD_LEN(32)) bus ();

  data_mem_pipe #(
    .WORD_LEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(1024), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .clr_i(clr_i), .init_busy_o(init_busy_o), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: compare every presented response against the queue head.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        mon_e = sb.pop_front();
        if (bus.rsp_rdata !== mon_e.data || bus.rsp_err !== mon_e.err ||
            (cyc - mon_e.acc) != LAT - 1) begin
          errors++;
          $display("FAIL rsp: got rdata=%h err=%b delay=%0d, required rdata=%h err=%b delay=%0d",
                   bus.rsp_rdata, bus.rsp_err, cyc - mon_e.acc,
                   mon_e.data, mon_e.err, LAT - 1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  // Called at a negedge; drives one request, queues its expected response
  // and returns at the next negedge (request accepted at the edge between).
  task automatic issue(input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int unsigned a;
    int          idx;
    chk("req_ready_at_issue", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    a      = addr - (addr % 4);
    e.acc  = cyc + 1;
    e.data = '0;
    e.err  = 1'b0;
    if (a >= 32'h800) begin
      e.err = 1'b1;
    end else if (a >= 32'h400) begin
      idx = int'((a - 32'h400) / 4);
      if (we) begin
        // Byte at word offset k is enabled by be[3-k] and is data byte 3-k.
        for (int k = 0; k < 4; k++)
          if (be[3-k]) model[idx][31-8*k -: 8] = wd[31-8*k -: 8];
      end else begin
        e.data = model[idx];
      end
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Counts negedges with init_busy high, starting at the current negedge.
  // A clr pulse is injected mid-sweep; it must not restart the sweep.
  task automatic wait_sweep(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (init_busy_o === 1'b1 && n < 2000) begin
      if (bus.req_ready !== 1'b0) bad++;
      n++;
      clr_i = (n == 100);
      @(negedge clk);
    end
    clr_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("queue_drained", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    idle();
    model_clear();

    // Reset asserted before any clock edge: outputs must be at reset values.
    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_init_busy", {31'b0, init_busy_o}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_sweep(sweep_n, rdy_bad);
    chk("sweep_len_reset", sweep_n, DEPTH);
    chk("ready_low_in_sweep", rdy_bad, 32'd0);
    chk("ready_after_sweep", {31'b0, bus.req_ready}, 32'd1);

    // Directed accesses.
    issue(1'b0, 4'hF, 32'h400, 32'h0);
    issue(1'b1, 4'hF, 32'h404, 32'hAABBCCDD);
    issue(1'b0, 4'hF, 32'h404, 32'h0);
    issue(1'b1, 4'h4, 32'h404, 32'h00110000);
    issue(1'b0, 4'hF, 32'h404, 32'h0);
    issue(1'b0, 4'h0, 32'h406, 32'h0);
    issue(1'b1, 4'h0, 32'h404, 32'hFFFFFFFF);
    issue(1'b0, 4'hF, 32'h404, 32'h0);
    idle(); @(negedge clk);
    issue(1'b1, 4'hF, 32'h408, 32'h01020304);
    issue(1'b0, 4'hF, 32'h400, 32'h0);
    issue(1'b0, 4'hF, 32'h404, 32'h0);
    issue(1'b0, 4'hF, 32'h408, 32'h0);
    issue(1'b1, 4'hF, 32'h7FC, 32'hCAFEF00D);
    issue(1'b0, 4'hF, 32'h3FC, 32'h0);
    issue(1'b1, 4'hF, 32'h3FC, 32'h55555555);
    issue(1'b0, 4'hF, 32'h3FC, 32'h0);
    issue(1'b1, 4'hF, 32'h800, 32'hDEADBEEF);
    issue(1'b0, 4'hF, 32'h800, 32'h0);
    issue(1'b0, 4'hF, 32'h7FC, 32'h0);
    issue(1'b0, 4'hF, 32'h7FF, 32'h0);
    idle();
    drain();

    // Randomised traffic with idle gaps, biased towards a small window so
    // reads frequently hit recently written words.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(); @(negedge clk);
      end else begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      ra = 32'h3C0 + $urandom_range(0, 63);
        else if (r == 1) ra = 32'h800 + $urandom_range(0, 63);
        else if (r < 6)  ra = 32'h400 + $urandom_range(0, 63);
        else             ra = 32'h400 + $urandom_range(0, 1023);
        issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom);
      end
    end
    idle();

    // Full readback confirms no stray writes landed anywhere.
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 4'hF, 32'h400 + 32'(i * 4), 32'h0);
    idle();
    drain();

    // clr in RUN with a read accepted in the same cycle.
    issue(1'b1, 4'hF, 32'h400, 32'h12345678);
    clr_i = 1'b1;
    issue(1'b0, 4'hF, 32'h400, 32'h0);
    clr_i = 1'b0;
    idle();
    chk("clr_init_busy", {31'b0, init_busy_o}, 32'd1);
    model_clear();
    wait_sweep(sweep_n, rdy_bad);
    chk("sweep_len_clr", sweep_n, DEPTH);
    chk("ready_low_in_clr_sweep", rdy_bad, 32'd0);
    issue(1'b0, 4'hF, 32'h400, 32'h0);
    issue(1'b1, 4'hF, 32'h410, 32'h87654321);
    idle();
    drain();

    // Reset with two reads in flight: they must never be answered.
    issue(1'b0, 4'hF, 32'h410, 32'h0);
    issue(1'b0, 4'hF, 32'h400, 32'h0);
    idle();
    rst = 1'b1;
    sb.delete();
    model_clear();
    #1;
    chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("midrst_init_busy", {31'b0, init_busy_o}, 32'd1);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    wait_sweep(sweep_n, rdy_bad);
    chk("sweep_len_midrst", sweep_n, DEPTH);
    issue(1'b0, 4'hF, 32'h410, 32'h0);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
